// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : PC owner and instruction-fetch sequencer (req/ready to memory,
//              valid/ready to decode). Optional perf counters: FETCH_PERF_CNT_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
   parameter int               ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR  = '0,
   parameter int               PC_STEP     = 4,
   parameter logic [5:0]       HALT_OPCODE = 6'h3F
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   output logic              halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] c_step  = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] c_align = ~(c_step - ADDR_W'(1));

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic                w_load;
   logic [ADDR_W-1:0]   w_redir_pc;

   assign w_redir_pc = redirect_pc & c_align;
   assign mem_addr   = r_pc;

   // Redirect outranks everything, including a same-cycle memory response
   // or downstream acceptance.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect) begin
               w_pc_nxt = w_redir_pc;
            end else if (mem_ready) begin
               w_load      = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = ST_FETCH;
            end else if (inst_ready) begin
               if (inst[31:26] == HALT_OPCODE) begin
                  w_state_nxt = ST_HALT;
               end else begin
                  w_pc_nxt    = r_pc + c_step;
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            if (redirect) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= BOOT_ADDR;
         mem_req    <= 1'b0;
         inst_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         mem_req    <= (w_state_nxt == ST_FETCH);
         inst_valid <= (w_state_nxt == ST_HOLD);
         halted     <= (w_state_nxt == ST_HALT);
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         inst    <= '0;
         inst_pc <= '0;
      end else if (w_load) begin
         inst    <= mem_rdata;
         inst_pc <= r_pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (inst_valid && inst_ready && (fetch_count != '1))
            fetch_count <= fetch_count + 32'd1;
         if ((r_state == ST_FETCH) && !mem_ready && (stall_count != '1))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : directed vector table, hand sequences and a randomized run
//                 against a transaction-level reference model of fetch_ctrl.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        inst_ready = 1'b0;
   logic        mem_req, inst_valid, halted;
   logic [31:0] mem_addr, inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif

   fetch_ctrl dut (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count(fetch_count),
      .stall_count(stall_count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                       input bit mr, input logic [31:0] md, input bit ir);
      start = st; redirect = rd; redirect_pc = rpc;
      mem_ready = mr; mem_rdata = md; inst_ready = ir;
      @(posedge CLK);
      #1;
   endtask

   typedef struct {
      bit          st, rd;
      logic [31:0] rpc;
      bit          mr;
      logic [31:0] md;
      bit          ir;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_inst, e_ipc;
      bit          e_halt;
   } vec_t;

   function automatic vec_t mk(bit st, bit rd, logic [31:0] rpc, bit mr, logic [31:0] md, bit ir,
                               bit e_req, logic [31:0] e_addr, bit e_valid,
                               logic [31:0] e_inst, logic [31:0] e_ipc, bit e_halt);
      vec_t v;
      v.st = st; v.rd = rd; v.rpc = rpc; v.mr = mr; v.md = md; v.ir = ir;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_halt = e_halt;
      return v;
   endfunction

   function automatic logic [31:0] memword(logic [31:0] a);
      return a * 32'h9E3779B1 + 32'h01234567;
   endfunction

   vec_t vecs [20];

   // reference model: what the sequencer is currently doing
   localparam int P_IDLE = 0, P_WAIT_MEM = 1, P_OFFER = 2, P_STOP = 3;
   int          m_phase;
   logic [31:0] m_pc, m_inst, m_ipc;
   logic [31:0] m_fc, m_sc;

   initial begin
      vecs[0]  = mk(1,0,0,        0,0,           0, 1,32'h0,  0,32'h0,       32'h0,  0);
      vecs[1]  = mk(0,0,0,        1,32'h13,      0, 0,32'h0,  1,32'h13,      32'h0,  0);
      vecs[2]  = mk(0,0,0,        0,0,           1, 1,32'h4,  0,32'h13,      32'h0,  0);
      vecs[3]  = mk(0,0,0,        1,32'h13,      0, 0,32'h4,  1,32'h13,      32'h4,  0);
      vecs[4]  = mk(0,0,0,        0,0,           1, 1,32'h8,  0,32'h13,      32'h4,  0);
      for (int i = 5; i < 8; i++)
         vecs[i] = mk(0,0,0,      0,0,           0, 1,32'h8,  0,32'h13,      32'h4,  0);
      vecs[8]  = mk(0,0,0,        1,32'h12345678,0, 0,32'h8,  1,32'h12345678,32'h8,  0);
      for (int i = 9; i < 14; i++)
         vecs[i] = mk(0,0,0,      0,0,           0, 0,32'h8,  1,32'h12345678,32'h8,  0);
      vecs[14] = mk(0,0,0,        0,0,           1, 1,32'hC,  0,32'h12345678,32'h8,  0);
      vecs[15] = mk(0,1,32'h102,  1,32'hDEADBEEF,0, 1,32'h100,0,32'h12345678,32'h8,  0);
      vecs[16] = mk(0,0,0,        1,32'hFC000000,0, 0,32'h100,1,32'hFC000000,32'h100,0);
      vecs[17] = mk(0,0,0,        0,0,           1, 0,32'h100,0,32'hFC000000,32'h100,1);
      vecs[18] = mk(1,0,0,        0,0,           0, 0,32'h100,0,32'hFC000000,32'h100,1);
      vecs[19] = mk(0,1,32'h40,   0,0,           0, 1,32'h40, 0,32'hFC000000,32'h100,0);

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(negedge CLK);
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].mr, vecs[i].md, vecs[i].ir);
         chk($sformatf("vec%0d_mem_req", i),    mem_req,    vecs[i].e_req);
         chk($sformatf("vec%0d_mem_addr", i),   mem_addr,   vecs[i].e_addr);
         chk($sformatf("vec%0d_inst_valid", i), inst_valid, vecs[i].e_valid);
         chk($sformatf("vec%0d_inst", i),       inst,       vecs[i].e_inst);
         chk($sformatf("vec%0d_inst_pc", i),    inst_pc,    vecs[i].e_ipc);
         chk($sformatf("vec%0d_halted", i),     halted,     vecs[i].e_halt);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("tbl_fetch_count", fetch_count, 32'd4);
      chk("tbl_stall_count", stall_count, 32'd3);
`endif

      // reset asserted mid-FETCH clears outputs without waiting for a clock
      step(0,0,0,0,0,0);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_mem_req", mem_req, 0);
      chk("midrst_inst_valid", inst_valid, 0);
      chk("midrst_inst", inst, 0);
      chk("midrst_inst_pc", inst_pc, 0);
      chk("midrst_mem_addr", mem_addr, 0);
      @(negedge CLK);
      reset = 1'b1;
      step(0,0,0,0,0,0);
      chk("idle_mem_req", mem_req, 0);
      step(0,1,32'h80,0,0,0);
      chk("idle_redir_mem_req", mem_req, 0);
      chk("idle_redir_addr", mem_addr, 0);
      step(1,0,0,0,0,0);
      chk("restart_mem_req", mem_req, 1);
      chk("restart_addr", mem_addr, 0);

      // wrap-around and redirect overriding an accepted handshake
      step(0,1,32'hFFFFFFFE,0,0,0);
      chk("wrap_redir_addr", mem_addr, 32'hFFFFFFFC);
      step(0,0,0,1,32'h13,0);
      chk("wrap_inst_pc", inst_pc, 32'hFFFFFFFC);
      step(0,0,0,0,0,1);
      chk("wrap_addr", mem_addr, 0);
      chk("wrap_mem_req", mem_req, 1);
      step(0,0,0,1,32'h13,0);
      chk("hold_valid", inst_valid, 1);
      step(0,1,32'h203,0,0,1);
      chk("acc_redir_addr", mem_addr, 32'h200);
      chk("acc_redir_valid", inst_valid, 0);

      // randomized run against the reference model
      reset = 1'b0;
      step(0,0,0,0,0,0);
      @(negedge CLK);
      reset = 1'b1;
      m_phase = P_IDLE; m_pc = 0; m_inst = 0; m_ipc = 0; m_fc = 0; m_sc = 0;
      for (int c = 0; c < 3000; c++) begin
         start       = ($urandom_range(0, 7) == 0);
         redirect    = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom;
         mem_ready   = ($urandom_range(0, 2) == 0);
         mem_rdata   = mem_ready ? memword(mem_addr) : $urandom;
         inst_ready  = $urandom_range(0, 1);

         if (m_phase == P_OFFER && inst_ready) m_fc++;
         if (m_phase == P_WAIT_MEM && !mem_ready) m_sc++;
         if (m_phase != P_IDLE && redirect) begin
            m_pc    = redirect_pc & ~32'd3;
            m_phase = P_WAIT_MEM;
         end else if (m_phase == P_IDLE) begin
            if (start) m_phase = P_WAIT_MEM;
         end else if (m_phase == P_WAIT_MEM) begin
            if (mem_ready) begin
               m_inst  = memword(m_pc);
               m_ipc   = m_pc;
               m_phase = P_OFFER;
            end
         end else if (m_phase == P_OFFER && inst_ready) begin
            if (m_inst[31:26] == 6'h3F) begin
               m_phase = P_STOP;
            end else begin
               m_pc    = m_pc + 32'd4;
               m_phase = P_WAIT_MEM;
            end
         end

         @(posedge CLK);
         #1;
         chk("rnd_mem_req", mem_req, m_phase == P_WAIT_MEM);
         chk("rnd_inst_valid", inst_valid, m_phase == P_OFFER);
         chk("rnd_halted", halted, m_phase == P_STOP);
         chk("rnd_mem_addr", mem_addr, m_pc);
         if (m_phase == P_OFFER) begin
            chk("rnd_inst", inst, m_inst);
            chk("rnd_inst_pc", inst_pc, m_ipc);
         end
      end
`ifdef FETCH_PERF_CNT_EN
      chk("rnd_fetch_count", fetch_count, m_fc);
      chk("rnd_stall_count", stall_count, m_sc);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
